// File: rtl/fsqrt_seq_if.sv
// Operand/result handshake bundle between the FPU issue stage, the sequential
// square-root unit and writeback.
interface fsqrt_seq_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d;
    logic        overflow;
    logic        underflow;
    logic        busy;

    modport master (
        output s_valid, s, d_ready,
        input  s_ready, d_valid, d, overflow, underflow, busy
    );

    modport slave (
        input  s_valid, s, d_ready,
        output s_ready, d_valid, d, overflow, underflow, busy
    );
endinterface

// File: rtl/fsqrt_seq.sv
// Sequential IEEE-754 single-precision square root, bit-serial restoring
// recurrence, one root bit per clock, round-to-nearest-even.
//
// state | meaning
// IDLE  | waiting for an operand, s_ready=1
// SPEC  | special operand (zero/denormal/negative/inf/NaN), load fixed result
// CALC  | one root bit per cycle, 25 iterations (24 result bits + guard)
// RND   | sticky, round, pack result
// DONE  | d_valid=1, hold d until writeback takes it
module fsqrt_seq #(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rstn,
    fsqrt_seq_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SPEC = 3'd1;
    localparam logic [2:0] CALC = 3'd2;
    localparam logic [2:0] RND  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] op_q, op_d;
    logic [25:0] rad_q, rad_d;
    logic [27:0] rem_q, rem_d;
    logic [24:0] q_q, q_d;
    logic [31:0] d_q, d_d;

    logic [7:0]  s_e;
    logic        s_spec;
    logic [25:0] rad_init;
    logic [31:0] spec_val;
    logic [27:0] rem_sh;
    logic [27:0] trial;
    logic        round_up;
    logic [22:0] man_rnd;
    logic [7:0]  e_d;

    assign s_e    = bus.s[30:23];
    assign s_spec = (s_e == 8'h00) || bus.s[31] || (s_e == 8'hFF);
    // Odd biased exponent means an even true exponent: radicand in [1,2).
    assign rad_init = bus.s[23] ? {1'b0, 1'b1, bus.s[22:0], 1'b0}
                                : {1'b1, bus.s[22:0], 2'b00};

    always_comb begin
        spec_val = 32'h7FC0_0000;
        if (op_q[30:23] == 8'h00)
            spec_val = {op_q[31], 31'b0};
        else if (!op_q[31] && (op_q[22:0] == 23'd0))
            spec_val = 32'h7F80_0000;
    end

    assign rem_sh = {rem_q[25:0], rad_q[25:24]};
    assign trial  = rem_sh - {1'b0, q_q, 2'b01};

    // (e+127)>>1 split as (e>>1) + 63 + e[0]; the root cannot carry out of
    // the mantissa, so there is no exponent increment path.
    assign e_d      = {1'b0, op_q[30:24]} + 8'd63 + {7'd0, op_q[23]};
    assign round_up = ROUND_EN && q_q[0] && ((rem_q != 28'd0) || q_q[1]);
    assign man_rnd  = q_q[23:1] + {22'd0, round_up};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        q_d     = q_q;
        d_d     = d_q;
        case (state_q)
            IDLE: begin
                if (bus.s_valid) begin
                    op_d    = bus.s;
                    cnt_d   = 5'd0;
                    rad_d   = rad_init;
                    rem_d   = 28'd0;
                    q_d     = 25'd0;
                    state_d = s_spec ? SPEC : CALC;
                end
            end
            SPEC: begin
                d_d     = spec_val;
                state_d = DONE;
            end
            CALC: begin
                rad_d = {rad_q[23:0], 2'b00};
                if (!trial[27]) begin
                    rem_d = trial;
                    q_d   = {q_q[23:0], 1'b1};
                end else begin
                    rem_d = rem_sh;
                    q_d   = {q_q[23:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd24)
                    state_d = RND;
            end
            RND: begin
                d_d     = {1'b0, e_d, man_rnd};
                state_d = DONE;
            end
            DONE: begin
                if (bus.d_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 32'd0;
            rad_q   <= 26'd0;
            rem_q   <= 28'd0;
            q_q     <= 25'd0;
            d_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            d_q     <= d_d;
        end
    end

    assign bus.s_ready   = (state_q == IDLE);
    assign bus.d_valid   = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.d         = d_q;
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
endmodule
